// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM states, default vector
// base and the vector address helper.
package irq_ctrl_pkg;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_DISPATCH = 1'b1
  } irq_state_t;

  localparam int          IRQ_MAX       = 8;
  localparam logic [15:0] VEC_BASE_DFLT = 16'h0002;

  // Each vector slot is two words wide.
  function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                           input logic [7:0]  idx);
    return base + {7'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: bit 0 is the highest priority.
module irq_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     active,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i]) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// AVR interrupt controller: pending/mask registers, fixed-priority arbitration,
// accept pulse with vector, RETI strobe and the one-instruction hold rule.
//
// state      | meaning
// S_IDLE     | waiting for an enabled pending request at an instruction boundary
// S_DISPATCH | vector issued, waiting for the sequencer to finish entry
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ  = 8,
  parameter logic [15:0] VEC_BASE = VEC_BASE_DFLT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               sr_if,
  input  logic               inst_end,
  input  logic               op_reti,
  input  logic               tim_sr_en,
  input  logic               seq_irq_done,
  input  logic               mm_ifr_we,
  input  logic               mm_imsk_we,
  input  logic [7:0]         mm_io_wdata,
  output logic [7:0]         ifr,
  output logic [7:0]         imsk,
  output logic               irq_det,
  output logic [15:0]        irq_vec,
  output logic               irq_ret,
  output logic               irq_busy
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] ifr_q;
  logic [NUM_IRQ-1:0] imsk_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] acc_clr;
  logic [NUM_IRQ-1:0] sw_clr;
  logic               sr_if_q;
  logic               hold;
  logic               hold_set;
  logic               prio_valid;
  logic [IDX_W-1:0]   prio_idx;
  logic               accept;
  irq_state_t         state;

  irq_prio_enc #(
    .N     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .active (active),
    .valid  (prio_valid),
    .index  (prio_idx)
  );

  assign irq_ret  = op_reti & tim_sr_en;
  assign rise     = irq_src & ~src_q;
  assign active   = ifr_q & imsk_q;
  assign accept   = (state == S_IDLE) & inst_end & sr_if & ~hold & prio_valid;
  assign acc_clr  = accept ? (NUM_IRQ'(1) << prio_idx) : '0;
  assign sw_clr   = mm_ifr_we ? mm_io_wdata[NUM_IRQ-1:0] : '0;
  assign hold_set = (sr_if & ~sr_if_q) | irq_ret;

  assign ifr      = 8'(ifr_q);
  assign imsk     = 8'(imsk_q);
  assign irq_busy = (state == S_DISPATCH);

  // A fresh edge wins over both clear sources in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q   <= '0;
      ifr_q   <= '0;
      imsk_q  <= '0;
      sr_if_q <= 1'b0;
      hold    <= 1'b0;
    end else begin
      src_q   <= irq_src;
      ifr_q   <= rise | (ifr_q & ~acc_clr & ~sw_clr);
      sr_if_q <= sr_if;
      if (mm_imsk_we) imsk_q <= mm_io_wdata[NUM_IRQ-1:0];
      if (hold_set)      hold <= 1'b1;
      else if (inst_end) hold <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      irq_det <= 1'b0;
      irq_vec <= VEC_BASE;
    end else begin
      case (state)
        S_IDLE: begin
          irq_det <= accept;
          if (accept) begin
            state   <= S_DISPATCH;
            irq_vec <= vec_addr(VEC_BASE, 8'(prio_idx));
          end
        end
        S_DISPATCH: begin
          irq_det <= 1'b0;
          if (seq_irq_done) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          irq_det <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic
// against a behavioural reference model.
module tb_irq_ctrl;

  localparam logic [15:0] VB = 16'h0002;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic        sr_if, inst_end, op_reti, tim_sr_en, seq_irq_done;
  logic        mm_ifr_we, mm_imsk_we;
  logic [7:0]  mm_io_wdata;
  logic [7:0]  ifr, imsk;
  logic        irq_det, irq_ret, irq_busy;
  logic [15:0] irq_vec;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0]  m_ifr, m_imsk, m_src;
  logic        m_srif, m_hold, m_busy, m_det;
  logic [15:0] m_vec;

  irq_ctrl #(.NUM_IRQ(8), .VEC_BASE(VB)) dut (
    .clock        (clock),
    .reset        (reset),
    .irq_src      (irq_src),
    .sr_if        (sr_if),
    .inst_end     (inst_end),
    .op_reti      (op_reti),
    .tim_sr_en    (tim_sr_en),
    .seq_irq_done (seq_irq_done),
    .mm_ifr_we    (mm_ifr_we),
    .mm_imsk_we   (mm_imsk_we),
    .mm_io_wdata  (mm_io_wdata),
    .ifr          (ifr),
    .imsk         (imsk),
    .irq_det      (irq_det),
    .irq_vec      (irq_vec),
    .irq_ret      (irq_ret),
    .irq_busy     (irq_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ifr = 8'h00; m_imsk = 8'h00; m_src = 8'h00;
    m_srif = 1'b0; m_hold = 1'b0; m_busy = 1'b0; m_det = 1'b0;
    m_vec = VB;
  endtask

  // One clock of the controller's rules, evaluated from the current inputs.
  task automatic model_step();
    logic [7:0] act, nifr;
    int win;
    bit acc;
    if (reset) begin
      model_reset();
      return;
    end
    act = m_ifr & m_imsk;
    win = -1;
    for (int i = 7; i >= 0; i--) if (act[i]) win = i;
    acc = !m_busy && inst_end && sr_if && !m_hold && (win >= 0);
    for (int i = 0; i < 8; i++) begin
      if (irq_src[i] && !m_src[i])            nifr[i] = 1'b1;
      else if (acc && win == i)               nifr[i] = 1'b0;
      else if (mm_ifr_we && mm_io_wdata[i])   nifr[i] = 1'b0;
      else                                    nifr[i] = m_ifr[i];
    end
    m_ifr = nifr;
    if (mm_imsk_we) m_imsk = mm_io_wdata;
    if ((sr_if && !m_srif) || (op_reti && tim_sr_en)) m_hold = 1'b1;
    else if (inst_end)                                m_hold = 1'b0;
    m_src  = irq_src;
    m_srif = sr_if;
    if (!m_busy) begin
      m_det = acc;
      if (acc) begin
        m_busy = 1'b1;
        m_vec  = VB + 16'(2 * win);
      end
    end else begin
      m_det = 1'b0;
      if (seq_irq_done) m_busy = 1'b0;
    end
  endtask

  task automatic cmp_model();
    chk("ifr",  ifr,      m_ifr);
    chk("imsk", imsk,     m_imsk);
    chk("det",  irq_det,  m_det);
    chk("vec",  irq_vec,  m_vec);
    chk("busy", irq_busy, m_busy);
  endtask

  // Apply current inputs for one clock, check, then drop the pulse inputs.
  task automatic cyc();
    #1;
    chk("ret", irq_ret, op_reti & tim_sr_en);
    @(posedge clock);
    model_step();
    #1;
    cmp_model();
    inst_end = 0; op_reti = 0; tim_sr_en = 0; seq_irq_done = 0;
    mm_ifr_we = 0; mm_imsk_we = 0; mm_io_wdata = 8'h00;
  endtask

  task automatic wr_imsk(input logic [7:0] d);
    mm_imsk_we = 1; mm_io_wdata = d;
  endtask

  task automatic wr_ifr(input logic [7:0] d);
    mm_ifr_we = 1; mm_io_wdata = d;
  endtask

  initial begin
    reset = 1; irq_src = 0; sr_if = 0; inst_end = 0; op_reti = 0; tim_sr_en = 0;
    seq_irq_done = 0; mm_ifr_we = 0; mm_imsk_we = 0; mm_io_wdata = 0;
    model_reset();
    @(negedge clock);
    cyc(); cyc();
    reset = 0;
    cyc();
    chk("rst_ifr", ifr, 8'h00);
    chk("rst_vec", irq_vec, 16'h0002);
    chk("rst_busy", irq_busy, 1'b0);

    // basic accept
    wr_imsk(8'h04); cyc();
    sr_if = 1; cyc();
    inst_end = 1; cyc();
    irq_src[2] = 1; cyc();
    cyc();
    inst_end = 1; cyc();
    chk("basic_det", irq_det, 1'b1);
    chk("basic_vec", irq_vec, 16'h0006);
    chk("basic_ifr2", ifr[2], 1'b0);
    cyc();
    chk("basic_det_off", irq_det, 1'b0);
    seq_irq_done = 1; cyc();
    chk("basic_idle", irq_busy, 1'b0);
    irq_src = 0; cyc();

    // priority, minimum latency
    wr_imsk(8'h22); cyc();
    irq_src[1] = 1; irq_src[5] = 1; cyc();
    inst_end = 1; cyc();
    chk("prio_vec1", irq_vec, 16'h0004);
    seq_irq_done = 1; cyc();
    inst_end = 1; cyc();
    chk("prio_vec2", irq_vec, 16'h000C);
    chk("prio_det2", irq_det, 1'b1);
    seq_irq_done = 1; cyc();
    irq_src = 0; cyc();

    // hold after sr_if rise
    sr_if = 0; wr_imsk(8'h01); cyc();
    irq_src[0] = 1; cyc();
    sr_if = 1; cyc();
    inst_end = 1; cyc();
    chk("hold_sei_block", irq_det, 1'b0);
    inst_end = 1; cyc();
    chk("hold_sei_take", irq_det, 1'b1);
    seq_irq_done = 1; cyc();
    irq_src = 0; cyc();

    // hold after RETI
    wr_imsk(8'h00); cyc();
    irq_src[0] = 1; cyc();
    inst_end = 1; cyc();
    op_reti = 1; tim_sr_en = 1; wr_imsk(8'h01); cyc();
    inst_end = 1; cyc();
    chk("hold_reti_block", irq_det, 1'b0);
    inst_end = 1; cyc();
    chk("hold_reti_take", irq_det, 1'b1);
    seq_irq_done = 1; cyc();
    irq_src = 0; cyc();

    // masking and W1C
    irq_src[3] = 1; cyc();
    chk("mask_pend", ifr, 8'h08);
    for (int i = 0; i < 3; i++) begin
      inst_end = 1; cyc();
      chk("mask_noacc", irq_det, 1'b0);
    end
    wr_ifr(8'h08); cyc();
    chk("w1c_clear", ifr, 8'h00);
    irq_src[3] = 0; cyc();
    irq_src[3] = 1; wr_ifr(8'h08); cyc();
    chk("w1c_set_wins", ifr, 8'h08);
    wr_ifr(8'h08); cyc();
    irq_src = 0; cyc();

    // busy blocks acceptance, then reset mid-dispatch
    wr_imsk(8'h07); cyc();
    irq_src[0] = 1; cyc();
    inst_end = 1; cyc();
    chk("busy_first", irq_vec, 16'h0002);
    irq_src[1] = 1; inst_end = 1; cyc();
    chk("busy_block", irq_det, 1'b0);
    inst_end = 1; cyc();
    chk("busy_block2", irq_busy, 1'b1);
    seq_irq_done = 1; cyc();
    inst_end = 1; cyc();
    chk("busy_second", irq_vec, 16'h0004);
    irq_src[2] = 1; cyc();
    reset = 1; irq_src = 0;
    #1;
    chk("rst_mid_busy", irq_busy, 1'b0);
    chk("rst_mid_vec", irq_vec, 16'h0002);
    chk("rst_mid_ifr", ifr, 8'h00);
    model_reset();
    cyc();
    reset = 0; cyc();

    // one-cycle dispatch
    inst_end = 1; cyc();
    wr_imsk(8'h10); cyc();
    irq_src[4] = 1; cyc();
    inst_end = 1; cyc();
    chk("one_det", irq_det, 1'b1);
    seq_irq_done = 1; cyc();
    chk("one_busy", irq_busy, 1'b0);
    irq_src = 0; cyc();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      irq_src      = 8'($urandom);
      sr_if        = ($urandom_range(0, 7) != 0);
      inst_end     = ($urandom_range(0, 2) == 0);
      op_reti      = ($urandom_range(0, 9) == 0);
      tim_sr_en    = ($urandom_range(0, 1) == 0);
      seq_irq_done = ($urandom_range(0, 2) == 0);
      mm_ifr_we    = ($urandom_range(0, 9) == 0);
      mm_imsk_we   = ($urandom_range(0, 11) == 0);
      mm_io_wdata  = 8'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
